// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, divisor type and divisor helper for clk_div_multi
package clk_div_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DIV_VAL = 6;

  typedef logic [DEF_WIDTH-1:0] div_t;

  // A divisor of zero has no meaningful period, so it runs as divide-by-one.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - divisor configuration bus for clk_div_multi
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
) ();

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;

  modport master (output cfg_we, output cfg_ch, output cfg_div);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div);

endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, pending/active divisor, 50% duty output, tick
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             ch_en,
  input  logic             sync,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] a_q, p_q, cnt_q;
  logic [WIDTH-1:0] a_nxt, p_nxt, cnt_nxt, w_eff;
  logic             en_q, clk_p, clk_n;
  logic             running, clk_p_nxt;

  assign w_eff = WIDTH'(eff_div(32'(wdata)));

  // The first enabled edge only registers the enable, so the tick cycle sees cnt == 0.
  always_comb begin
    running = ch_en & en_q;
    a_nxt   = a_q;
    p_nxt   = p_q;
    cnt_nxt = '0;
    if (running) begin
      if (sync || (cnt_q == a_q - ONE)) begin
        a_nxt = p_q;
      end else begin
        cnt_nxt = cnt_q + ONE;
      end
    end else if (ch_en && sync) begin
      a_nxt = p_q;
    end
    if (we) begin
      p_nxt = w_eff;
      if (!running) a_nxt = w_eff;
    end
    clk_p_nxt = running && (cnt_nxt >= (a_nxt >> 1));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      a_q   <= WIDTH'(DEF_DIV);
      p_q   <= WIDTH'(DEF_DIV);
      cnt_q <= '0;
      en_q  <= 1'b0;
      clk_p <= 1'b0;
    end else begin
      a_q   <= a_nxt;
      p_q   <= p_nxt;
      cnt_q <= cnt_nxt;
      en_q  <= ch_en;
      clk_p <= clk_p_nxt;
    end
  end

  always_ff @(negedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) clk_n <= 1'b0;
    else            clk_n <= clk_p;
  end

  // Odd divisors trim the high phase by half a cycle using the negedge copy.
  always_comb begin
    if (a_q == ONE)  clk_out = sys_clk & en_q;
    else if (a_q[0]) clk_out = clk_p & clk_n;
    else             clk_out = clk_p;
  end

  assign tick       = en_q && (cnt_q == '0);
  assign div_active = a_q;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider top; CLKDIV_SYNC_EN adds sync_in
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  clk_div_multi_if.slave          cfg_bus,
  input  logic [NUM_CH-1:0]       ch_en,
`ifdef CLKDIV_SYNC_EN
  input  logic                    sync_in,
`endif
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH*WIDTH-1:0] div_active
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic sync;

`ifdef CLKDIV_SYNC_EN
  assign sync = sync_in;
`else
  assign sync = 1'b0;
`endif

  // Channel indices at or above NUM_CH match no decoder and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_i;
    assign we_i = cfg_bus.cfg_we && (cfg_bus.cfg_ch == CHW'(i));

    clk_div_chan #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .ch_en      (ch_en[i]),
      .sync       (sync),
      .we         (we_i),
      .wdata      (cfg_bus.cfg_div),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .div_active (div_active[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
`timescale 1ns/100ps
module tb_clk_div_multi;

  localparam int NUM_CH = 5;
  localparam int WIDTH  = 16;
  localparam int TW     = NUM_CH * WIDTH;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [TW-1:0]     div_active;
`ifdef CLKDIV_SYNC_EN
  logic              sync_in;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  clk_div_multi_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) cfg_if ();

  clk_div_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEF_DIV(6)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .cfg_bus    (cfg_if.slave),
    .ch_en      (ch_en),
`ifdef CLKDIV_SYNC_EN
    .sync_in    (sync_in),
`endif
    .clk_out    (clk_out),
    .tick       (tick),
    .div_active (div_active)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input int div);
    @(negedge sys_clk);
    cfg_if.cfg_we  = 1'b1;
    cfg_if.cfg_ch  = 3'(ch);
    cfg_if.cfg_div = 16'(div);
    @(negedge sys_clk);
    cfg_if.cfg_we  = 1'b0;
  endtask

  // High time and period of clk_out[ch] in half-cycles, sampled 2ns after every edge.
  task automatic measure(input int ch, output int hi, output int per);
    int n;
    int lo;
    hi = 0;
    lo = 0;
    @(posedge sys_clk);
    #2;
    n = 0;
    while (clk_out[ch] !== 1'b0 && n < 400) begin #5; n++; end
    n = 0;
    while (clk_out[ch] !== 1'b1 && n < 400) begin #5; n++; end
    while (clk_out[ch] === 1'b1 && hi < 400) begin hi++; #5; end
    while (clk_out[ch] === 1'b0 && lo < 400) begin lo++; #5; end
    per = hi + lo;
  endtask

  task automatic tick_period(input int ch, output int per);
    int n;
    n = 0;
    @(negedge sys_clk);
    while (tick[ch] !== 1'b1 && n < 200) begin @(negedge sys_clk); n++; end
    per = 0;
    do begin
      @(negedge sys_clk);
      per++;
    end while (tick[ch] !== 1'b1 && per < 200);
  endtask

  initial begin
    int hi, per, k;

    sys_rst_n      = 1'b0;
    ch_en          = '1;
    cfg_if.cfg_we  = 1'b0;
    cfg_if.cfg_ch  = '0;
    cfg_if.cfg_div = '0;
`ifdef CLKDIV_SYNC_EN
    sync_in        = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_clk_out", TW'(clk_out), TW'(0));
    check("rst_tick", TW'(tick), TW'(0));
    check("rst_div", div_active, {5{16'd6}});

    // Start-up: tick in the cycle after enable registers, first rise 3 cycles later
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    check("start_tick", TW'(tick), TW'(5'h1f));
    check("start_clk_e0", TW'(clk_out), TW'(0));
    @(posedge sys_clk); #1;
    check("start_tick_e1", TW'(tick), TW'(0));
    @(posedge sys_clk); #1;
    check("start_clk_e2", TW'(clk_out), TW'(0));
    @(posedge sys_clk); #1;
    check("start_clk_e3", TW'(clk_out), TW'(5'h1f));

    // Default N=6
    measure(0, hi, per);
    check("n6_hi", TW'(hi), TW'(6));
    check("n6_per", TW'(per), TW'(12));
    tick_period(0, per);
    check("n6_tick_per", TW'(per), TW'(6));
    measure(4, hi, per);
    check("n6_ch4_per", TW'(per), TW'(12));

    // Odd divide on ch1, written while disabled
    @(negedge sys_clk);
    ch_en[1] = 1'b0;
    repeat (2) @(negedge sys_clk);
    cfg_write(1, 5);
    check("n5_div_now", TW'(div_active[16 +: 16]), TW'(5));
    ch_en[1] = 1'b1;
    measure(1, hi, per);
    check("n5_hi", TW'(hi), TW'(5));
    check("n5_per", TW'(per), TW'(10));
    tick_period(1, per);
    check("n5_tick_per", TW'(per), TW'(5));

    // Update at boundary: write N=4 to ch0 while cnt == 2
    k = 0;
    @(negedge sys_clk);
    while (tick[0] !== 1'b1 && k < 20) begin @(negedge sys_clk); k++; end
    k = 0;
    @(negedge sys_clk); k++;
    @(negedge sys_clk); k++;
    cfg_if.cfg_we  = 1'b1;
    cfg_if.cfg_ch  = 3'd0;
    cfg_if.cfg_div = 16'd4;
    @(negedge sys_clk); k++;
    cfg_if.cfg_we  = 1'b0;
    check("upd_div_hold", TW'(div_active[15:0]), TW'(6));
    do begin
      @(negedge sys_clk);
      k++;
    end while (tick[0] !== 1'b1 && k < 20);
    check("upd_cur_period", TW'(k), TW'(6));
    check("upd_div_wrap", TW'(div_active[15:0]), TW'(4));
    tick_period(0, per);
    check("n4_tick_per", TW'(per), TW'(4));
    measure(0, hi, per);
    check("n4_hi", TW'(hi), TW'(4));
    check("n4_per", TW'(per), TW'(8));

    // N=0 on enabled ch2 becomes divide-by-one at its next wrap
    cfg_write(2, 0);
    repeat (8) @(negedge sys_clk);
    check("n0_div", TW'(div_active[32 +: 16]), TW'(1));
    for (int i = 0; i < 3; i++) begin
      check("n0_tick", TW'(tick[2]), TW'(1));
      @(negedge sys_clk);
    end
    @(posedge sys_clk); #2;
    check("n0_clk_hi", TW'(clk_out[2]), TW'(1));
    @(negedge sys_clk); #2;
    check("n0_clk_lo", TW'(clk_out[2]), TW'(0));
    measure(2, hi, per);
    check("n1_hi", TW'(hi), TW'(1));
    check("n1_per", TW'(per), TW'(2));

    // Out-of-range channel is ignored
    cfg_write(NUM_CH, 9);
    repeat (20) @(negedge sys_clk);
    check("bad_ch", div_active, {16'd6, 16'd6, 16'd1, 16'd5, 16'd4});

    // Disable ch3 while its output is high, then re-enable
    k = 0;
    @(negedge sys_clk);
    while (clk_out[3] !== 1'b1 && k < 20) begin @(negedge sys_clk); k++; end
    check("dis_high_before", TW'(clk_out[3]), TW'(1));
    ch_en[3] = 1'b0;
    @(posedge sys_clk); #1;
    check("dis_clk_low", TW'(clk_out[3]), TW'(0));
    check("dis_tick_low", TW'(tick[3]), TW'(0));
    repeat (3) @(negedge sys_clk);
    check("dis_clk_stays", TW'(clk_out[3]), TW'(0));
    ch_en[3] = 1'b1;
    @(posedge sys_clk); #1;
    check("reen_tick", TW'(tick[3]), TW'(1));
    @(posedge sys_clk); #1;
    check("reen_tick_one", TW'(tick[3]), TW'(0));

    // Asynchronous reset mid-run
    repeat (5) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("arst_clk_out", TW'(clk_out), TW'(0));
    check("arst_tick", TW'(tick), TW'(0));
    check("arst_div", div_active, {5{16'd6}});

`ifdef CLKDIV_SYNC_EN
    // Phase-align ch0 (N=4) and ch1 (N=6) from arbitrary phases
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ch_en[0]  = 1'b0;
    cfg_write(0, 4);
    repeat ($urandom_range(1, 7)) @(negedge sys_clk);
    ch_en[0] = 1'b1;
    repeat ($urandom_range(3, 9)) @(negedge sys_clk);
    sync_in = 1'b1;
    @(negedge sys_clk);
    sync_in = 1'b0;
    #6;
    check("sync_ticks", TW'(tick), TW'(5'h1f));
    tick_period(0, per);
    check("sync_n4_per", TW'(per), TW'(4));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
